// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the shift-add multiplier: WIDTH iterations per multiply, run/ready handshake.
// Define MULT_CTRL_TWO_PHASE_EN to split each iteration into separate ADD and SHIFT cycles.
module mult_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             product_lsb,
   output logic             load_ctrl,
   output logic             alu_en,
   output logic             w_ctrl,
   output logic             srl_ctrl,
   output logic             ready,
   output logic             busy,
   output logic [CNT_W-1:0] iter
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef MULT_CTRL_TWO_PHASE_EN
   localparam logic [2:0] ST_ADD   = 3'd4;
   localparam logic [2:0] ST_SHIFT = 3'd5;
   localparam logic [2:0] ST_FIRST = ST_ADD;
`else
   localparam logic [2:0] ST_CALC  = 3'd2;
   localparam logic [2:0] ST_FIRST = ST_CALC;
`endif

   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_LOAD;
               iter_d  = '0;
            end
         end
         ST_LOAD: begin
            state_d = ST_FIRST;
            iter_d  = '0;
         end
`ifdef MULT_CTRL_TWO_PHASE_EN
         ST_ADD: begin
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            iter_d  = iter_q + ITER_ONE;
            state_d = (iter_q == ITER_LAST) ? ST_DONE : ST_ADD;
         end
`else
         ST_CALC: begin
            iter_d  = iter_q + ITER_ONE;
            state_d = (iter_q == ITER_LAST) ? ST_DONE : ST_CALC;
         end
`endif
         ST_DONE: begin
            if (!run) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            iter_d  = '0;
         end
      endcase
   end

   // w_ctrl/alu_en follow product_lsb combinationally: Product adds and shifts on the same edge.
   always_comb begin
      load_ctrl = 1'b0;
      alu_en    = 1'b0;
      w_ctrl    = 1'b0;
      srl_ctrl  = 1'b0;
      ready     = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_LOAD: begin
            load_ctrl = 1'b1;
            busy      = 1'b1;
         end
`ifdef MULT_CTRL_TWO_PHASE_EN
         ST_ADD: begin
            busy   = 1'b1;
            alu_en = product_lsb;
            w_ctrl = product_lsb;
         end
         ST_SHIFT: begin
            busy     = 1'b1;
            srl_ctrl = 1'b1;
         end
`else
         ST_CALC: begin
            busy     = 1'b1;
            srl_ctrl = 1'b1;
            alu_en   = product_lsb;
            w_ctrl   = product_lsb;
         end
`endif
         ST_DONE: begin
            ready = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: state flops use non-blocking assignments; reset is synchronous and overrides every state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

   assign iter = iter_q;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller for the shift-add multiplier datapath. It drives the Product register's load, write and shift-right controls and the ALU add enable. It runs exactly WIDTH iterations per multiply and signals completion with a run/ready handshake. It sits between the top-level multiplier wrapper and the Product register, Multiplicand register and ALU.

## Interface
- WIDTH, 32, operand width; number of iterations per multiply (≥1)
- CNT_W, $clog2(WIDTH)+1, iteration counter width
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- run  input  1  start request; level, sampled only in IDLE and DONE
- product_lsb  input  1  Product_out[0] from the Product register
- load_ctrl  output  1  Product loads Multiplier_in into low half and clears the high half
- alu_en  output  1  ALU adds Multiplicand to the Product high half
- w_ctrl  output  1  Product captures ALU_result/ALU_Carry into the high half
- srl_ctrl  output  1  Product shifts right by one
- ready  output  1  result valid in Product; also routed to Product.ready
- busy  output  1  multiply in progress (LOAD or CALC states)
- iter  output  CNT_W  completed iteration count

## Operation
- States: IDLE, LOAD, CALC (plus ADD/SHIFT, see Configuration), DONE.
- IDLE: all controls 0. When run=1 → LOAD.
- LOAD: load_ctrl=1, busy=1, iter cleared to 0. Lasts one cycle, then → CALC.
- CALC (single-phase), one cycle per iteration:
  - srl_ctrl=1.
  - w_ctrl=alu_en=product_lsb. This is combinational from product_lsb, because Product performs add-then-shift in one edge.
  - iter increments on every CALC edge.
  - When iter reaches WIDTH-1 on the current edge (last iteration) → DONE.
- DONE: ready=1 and busy=0, all other controls 0, iter holds WIDTH. Stays in DONE while run=1. When run=0 → IDLE, and ready falls on that edge.
- No auto-restart: a new multiply requires run to go low and then high again.
- run changes during LOAD/CALC are ignored. A multiply cannot be aborted except by reset.
- load_ctrl, w_ctrl and srl_ctrl are never asserted together with ready.
- iter never exceeds WIDTH and never wraps.

## Timing
- Reset (reset=0 at a rising edge), from that edge:
  - state=IDLE, iter=0.
  - load_ctrl=alu_en=w_ctrl=srl_ctrl=ready=busy=0.
  - Reset has priority over every state, including mid-CALC. No partial iteration completes.
- Single-phase latency:
  - Edge E0 samples run=1 in IDLE.
  - LOAD occupies the cycle after E0.
  - CALC occupies the cycles after E1..E_WIDTH.
  - ready=1 after edge E_(WIDTH+1), i.e. 33 edges for WIDTH=32.
- Handshake: ready stays high for as long as run stays high. Once run=0 is sampled in DONE, ready=0 after the next edge.
- Simultaneous run=1 and reset=0: reset wins.
- w_ctrl/alu_en in a CALC cycle reflect product_lsb sampled in that same cycle, i.e. the post-shift value from the previous iteration.
- WIDTH=1: LOAD, one CALC, then DONE. ready after E2.

## Configuration
- MULT_CTRL_TWO_PHASE_EN undefined (default): single-phase CALC as described above.
- MULT_CTRL_TWO_PHASE_EN defined: CALC is replaced by a two-cycle iteration.
  - ADD cycle: alu_en=w_ctrl=product_lsb, srl_ctrl=0.
  - SHIFT cycle: srl_ctrl=1, w_ctrl=0, alu_en=0. iter increments on the SHIFT edge.
  - Order is ADD → SHIFT → ADD … The last SHIFT goes → DONE.
  - ready after E_(2·WIDTH+1), i.e. 65 edges for WIDTH=32.
  - All other states, reset behaviour and handshake are unchanged.

## Test plan
- Reset: hold reset=0 for 2 edges with run=1 → every output 0, iter=0, and no LOAD occurs. Release reset with run=1 → load_ctrl=1 for exactly one cycle after the next edge.
- Full multiply, Product behavioural model, multiplier 0x0000_0005, WIDTH=32:
  - w_ctrl high only in iterations 0 and 2.
  - srl_ctrl high for 32 consecutive cycles.
  - ready after edge 33 (two-phase: w_ctrl in ADD cycles 0 and 2; ready after edge 65).
- Multiplier 0xFFFF_FFFF, multiplicand 0xFFFF_FFFF → w_ctrl in all 32 iterations. Final Product = 0xFFFF_FFFE_0000_0001 when ready rises.
- Handshake: hold run=1 for 10 cycles after ready → ready stays 1 and no new load_ctrl. Drop run → ready=0 after the next edge and IDLE. Raise run again → new LOAD.
- Reset mid-operation: assert reset=0 at CALC iteration 17 → next edge gives IDLE, srl_ctrl=0, iter=0. No ready pulse.
- run toggled 0/1 every cycle during CALC → no effect. Iteration count is still 32 and ready timing is unchanged.
